// File: rtl/step_pulse_gen.sv
// Multi-mode step-pulse generator: fixed walk/jog/run rates, a per-second hybrid
// rate profile or off, plus a 1 Hz tick and a saturating step counter.
module step_pulse_gen #(
    parameter int unsigned  CLK_HZ    = 100_000_000,
    parameter int unsigned  RATE0     = 32,
    parameter int unsigned  RATE1     = 64,
    parameter int unsigned  RATE2     = 128,
    parameter int unsigned  HYB_LEN   = 4,
    parameter logic [127:0] HYB_RATES = {8{16'd0}},
    parameter int unsigned  CNT_W     = 16
) (
    input  logic             clk100Mhz,
    input  logic             resetN,
    input  logic [1:0]       sw32,
    input  logic             enable,
    input  logic             hybridEn,
    output logic             stepPulse,
    output logic             secTick,
    output logic [CNT_W-1:0] stepCount,
    output logic [15:0]      activeRate
);

    localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] SEC_LAST = PW'(CLK_HZ - 1);

    // Periods are held as "last count" (PERIOD-1); a zero rate or a zero
    // quotient both collapse to PERIOD=1.
    function automatic logic [PW-1:0] period_last(input int unsigned rate);
        int unsigned p;
        p = (rate == 0) ? 1 : CLK_HZ / rate;
        if (p == 0) p = 1;
        return PW'(p - 1);
    endfunction

    function automatic logic [8*PW-1:0] hyb_last_table();
        logic [8*PW-1:0] t;
        t = '0;
        for (int k = 0; k < 8; k++)
            t[k*PW +: PW] = period_last(32'(HYB_RATES[16*k +: 16]));
        return t;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == '1) ? c : c + 1'b1;
    endfunction

    localparam logic [PW-1:0]   LAST0    = period_last(RATE0);
    localparam logic [PW-1:0]   LAST1    = period_last(RATE1);
    localparam logic [PW-1:0]   LAST2    = period_last(RATE2);
    localparam logic [8*PW-1:0] HYB_LAST = hyb_last_table();
    localparam logic [2:0]      SEG_END  = 3'(HYB_LEN - 1);

    logic [1:0]    sw_p0;
    logic [1:0]    mode_q;
    logic [1:0]    mode_prev;
    logic [PW-1:0] period_cnt;
    logic [PW-1:0] sec_cnt;
    logic [2:0]    seg_idx;
    logic [15:0]   rate_sel;
    logic [PW-1:0] last_sel;
    logic          hyb_on;
    logic          mode_chg;
    logic          sec_done;
    logic          step_done;

    always_comb begin
        rate_sel = '0;
        last_sel = '0;
        hyb_on   = (mode_q == 2'd3) && hybridEn;
        case (mode_q)
            2'd0: begin rate_sel = 16'(RATE0); last_sel = LAST0; end
            2'd1: begin rate_sel = 16'(RATE1); last_sel = LAST1; end
            2'd2: begin rate_sel = 16'(RATE2); last_sel = LAST2; end
            default: begin
                if (hybridEn) begin
                    rate_sel = HYB_RATES[16*seg_idx +: 16];
                    last_sel = HYB_LAST[PW*seg_idx +: PW];
                end
            end
        endcase
        mode_chg  = (mode_q != mode_prev);
        sec_done  = (sec_cnt == SEC_LAST);
        step_done = (rate_sel != '0) && (period_cnt == last_sel);
    end

    always_ff @(posedge clk100Mhz or negedge resetN) begin
        if (!resetN) begin
            sw_p0      <= '0;
            mode_q     <= '0;
            mode_prev  <= '0;
            period_cnt <= '0;
            sec_cnt    <= '0;
            seg_idx    <= '0;
            stepCount  <= '0;
            stepPulse  <= 1'b0;
            secTick    <= 1'b0;
            activeRate <= '0;
        end else begin
            sw_p0      <= sw32;
            mode_q     <= sw_p0;
            mode_prev  <= mode_q;
            activeRate <= rate_sel;
            stepPulse  <= 1'b0;
            secTick    <= 1'b0;
            // A mode change restarts the profile from a clean second.
            if (mode_chg) begin
                period_cnt <= '0;
                sec_cnt    <= '0;
                seg_idx    <= '0;
            end else if (enable) begin
                stepPulse <= step_done;
                secTick   <= sec_done;
                sec_cnt   <= sec_done ? '0 : sec_cnt + 1'b1;
                if (step_done)
                    stepCount <= sat_inc(stepCount);
                if (hyb_on && sec_done) begin
                    period_cnt <= '0;
                    seg_idx    <= (seg_idx == SEG_END) ? '0 : seg_idx + 1'b1;
                end else if (step_done || rate_sel == '0) begin
                    period_cnt <= '0;
                end else begin
                    period_cnt <= period_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_step_pulse_gen.sv
// Bench for step_pulse_gen: directed scenarios plus a randomized phase, all
// checked every cycle against an enabled-cycle-count model of the step profile.
module tb_step_pulse_gen;

    localparam int CLK_HZ  = 1000;
    localparam int HYB_LEN = 2;
    localparam int CNT_MAX = 15;

    logic        clk100Mhz = 1'b0;
    logic        resetN    = 1'b1;
    logic [1:0]  sw32      = 2'd0;
    logic        enable    = 1'b0;
    logic        hybridEn  = 1'b0;
    logic        stepPulse;
    logic        secTick;
    logic [3:0]  stepCount;
    logic [15:0] activeRate;

    step_pulse_gen #(
        .CLK_HZ(1000), .RATE0(10), .RATE1(20), .RATE2(1000), .HYB_LEN(2),
        .HYB_RATES({96'd0, 16'd0, 16'd5}), .CNT_W(4)
    ) dut (
        .clk100Mhz(clk100Mhz), .resetN(resetN), .sw32(sw32), .enable(enable),
        .hybridEn(hybridEn), .stepPulse(stepPulse), .secTick(secTick),
        .stepCount(stepCount), .activeRate(activeRate)
    );

    always #5 clk100Mhz = ~clk100Mhz;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: everything follows from the number of enabled cycles
    // since the last restart (reset or mode change).
    function automatic int hyb_rate(input int seg);
        return (seg == 0) ? 5 : 0;
    endfunction

    function automatic int mode_rate(input int mode, input bit hyb, input int n_before);
        case (mode)
            0: return 10;
            1: return 20;
            2: return 1000;
            default: return hyb ? hyb_rate((n_before / CLK_HZ) % HYB_LEN) : 0;
        endcase
    endfunction

    function automatic int period_of(input int r);
        int p;
        if (r == 0) return 1;
        p = CLK_HZ / r;
        return (p == 0) ? 1 : p;
    endfunction

    int   m_n = 0, m_mode = 0, m_pend = 0, m_pend_mode = 0, m_sw_last = 0, m_cnt = 0;
    logic e_step = 1'b0, e_sec = 1'b0;
    int   e_rate = 0;

    always @(negedge resetN) begin
        m_n = 0; m_mode = 0; m_pend = 0; m_sw_last = 0; m_cnt = 0;
        e_step = 1'b0; e_sec = 1'b0; e_rate = 0;
    end

    always @(posedge clk100Mhz) begin
        int s, j, r;
        if (resetN) begin
            if (m_pend == 1) begin
                m_pend = 0; m_mode = m_pend_mode; m_n = 0;
                e_step = 1'b0; e_sec = 1'b0;
                e_rate = mode_rate(m_mode, hybridEn, 0);
            end else begin
                if (m_pend == 2) m_pend = 1;
                e_rate = mode_rate(m_mode, hybridEn, m_n);
                e_step = 1'b0; e_sec = 1'b0;
                if (enable) begin
                    m_n++;
                    e_sec = (m_n % CLK_HZ == 0);
                    if (m_mode == 3 && hybridEn) begin
                        s = (m_n - 1) / CLK_HZ;
                        j = m_n - CLK_HZ * s;
                        r = hyb_rate(s % HYB_LEN);
                        e_step = (r != 0) && (j % period_of(r) == 0);
                    end else begin
                        r = mode_rate(m_mode, hybridEn, 0);
                        e_step = (r != 0) && (m_n % period_of(r) == 0);
                    end
                    if (e_step && m_cnt < CNT_MAX) m_cnt++;
                end
            end
            if (int'(sw32) != m_sw_last) begin
                m_sw_last = int'(sw32); m_pend = 2; m_pend_mode = int'(sw32);
            end
        end
    end

    always @(negedge clk100Mhz) begin
        check("stepPulse", int'(stepPulse), int'(e_step));
        check("secTick", int'(secTick), int'(e_sec));
        check("stepCount", int'(stepCount), m_cnt);
        check("activeRate", int'(activeRate), e_rate);
    end

    // Observation counters for the directed scenarios.
    int cyc = 0, step_tot = 0, sec_tot = 0, step_in_sec = 0, last_step_cyc = 0, last_gap = 0;
    int sec_q[$];

    always @(posedge clk100Mhz) cyc++;

    always @(posedge clk100Mhz) begin
        #1;
        if (stepPulse) begin
            step_tot++; step_in_sec++;
            last_gap = cyc - last_step_cyc;
            last_step_cyc = cyc;
        end
        if (secTick) begin
            sec_tot++;
            sec_q.push_back(step_in_sec);
            step_in_sec = 0;
        end
    end

    task automatic clear_meas();
        step_tot = 0; sec_tot = 0; step_in_sec = 0;
        sec_q.delete();
    endtask

    task automatic wait_step(input string name, input int limit, output int at_cyc);
        at_cyc = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk100Mhz);
            if (stepPulse) begin
                at_cyc = cyc;
                break;
            end
        end
        if (at_cyc < 0) check(name, 0, 1);
    endtask

    initial begin
        int t, sw_cyc, gap, cur, nsw;
        #2 resetN = 1'b0;
        repeat (3) @(negedge clk100Mhz);
        check("rst_stepCount", int'(stepCount), 0);
        check("rst_activeRate", int'(activeRate), 0);
        resetN = 1'b1; enable = 1'b1;
        clear_meas();

        // Walk: 10 strobes and one tick per second
        repeat (1000) @(negedge clk100Mhz);
        check("s1_strobes", step_tot, 10);
        check("s1_ticks", sec_tot, 1);
        check("s1_count", int'(stepCount), 10);
        check("s1_rate", int'(activeRate), 10);
        check("s1_gap", last_gap, 100);

        // Walk -> jog mid-period
        repeat (30) @(negedge clk100Mhz);
        sw32 = 2'd1; sw_cyc = cyc;
        repeat (3) @(negedge clk100Mhz);
        check("s2_count_kept", int'(stepCount), 10);
        check("s2_rate", int'(activeRate), 20);
        wait_step("s2_strobe_timeout", 100, t);
        check("s2_delay", t - sw_cyc, 53);
        check("s2_count", int'(stepCount), 11);

        // Run: PERIOD=1, counter saturates
        sw32 = 2'd2;
        repeat (23) @(negedge clk100Mhz);
        check("s3_pulse", int'(stepPulse), 1);
        check("s3_sat", int'(stepCount), 15);
        check("s3_rate", int'(activeRate), 1000);

        // Hybrid profile 5/0
        hybridEn = 1'b1; sw32 = 2'd3;
        repeat (3) @(negedge clk100Mhz);
        clear_meas();
        repeat (500) @(negedge clk100Mhz);
        check("s4_rate_seg0", int'(activeRate), 5);
        repeat (1000) @(negedge clk100Mhz);
        check("s4_rate_seg1", int'(activeRate), 0);
        repeat (2500) @(negedge clk100Mhz);
        check("s4_seconds", sec_q.size(), 4);
        for (int i = 0; i < sec_q.size() && i < 4; i++)
            check($sformatf("s4_sec%0d_strobes", i), sec_q[i], (i % 2 == 0) ? 5 : 0);

        // Mode 3 with hybrid disabled: off, ticks continue
        sw32 = 2'd1;
        repeat (10) @(negedge clk100Mhz);
        sw32 = 2'd3; hybridEn = 1'b0;
        repeat (3) @(negedge clk100Mhz);
        clear_meas();
        repeat (2000) @(negedge clk100Mhz);
        check("s5_strobes", step_tot, 0);
        check("s5_ticks", sec_tot, 2);
        check("s5_rate", int'(activeRate), 0);

        // Enable pause, then asynchronous reset between edges
        sw32 = 2'd0;
        repeat (153) @(negedge clk100Mhz);
        enable = 1'b0;
        repeat (37) @(negedge clk100Mhz);
        enable = 1'b1;
        wait_step("s6_strobe_timeout", 100, t);
        check("s6_gap", last_gap, 137);
        repeat (30) @(negedge clk100Mhz);
        @(posedge clk100Mhz);
        #2 resetN = 1'b0;
        #1;
        check("s6_rst_stepPulse", int'(stepPulse), 0);
        check("s6_rst_secTick", int'(secTick), 0);
        check("s6_rst_stepCount", int'(stepCount), 0);
        check("s6_rst_activeRate", int'(activeRate), 0);
        repeat (2) @(negedge clk100Mhz);
        resetN = 1'b1;

        // Randomized enables and mode switches
        gap = 50; cur = 0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk100Mhz);
            enable = ($urandom_range(0, 7) != 0);
            gap = gap - 1;
            if (gap == 0) begin
                nsw = int'($urandom_range(0, 3));
                if (nsw == cur) nsw = (nsw + 1) % 4;
                if (cur != 3) hybridEn = 1'($urandom_range(0, 1));
                sw32 = 2'(nsw);
                cur = nsw;
                gap = (nsw == 3) ? int'($urandom_range(1200, 2500)) : int'($urandom_range(20, 400));
            end
        end
        enable = 1'b1;
        repeat (5) @(negedge clk100Mhz);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
